crc_stream_dec: RTL
===================

Name: crc_stream_dec

Overview:
- Parametrised, beat-serial CRC checker for the ECC decoder family.
- Accepts a DATA_W-bit payload as DATA_W/BUS_W beats on a valid/ready stream, with the received CRC field on the last beat.
- Assembles the payload and computes the syndrome with an unrolled per-beat LFSR update.
- Presents the full payload plus error flags through an output valid/ready handshake. Keeps a saturating error counter for monitoring.

Parameters:
- DATA_W, 128: payload width; must be a multiple of BUS_W.
- BUS_W, 32: bits per input beat.
- CRC_W, 6: check-field width.
- POLY, 6'h03: generator polynomial without the implicit x^CRC_W term. Default is G(x)=x^6+x+1.
- CNT_W, 16: error-counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_valid  in  1  input beat valid.
- i_ready  out  1  block can accept a beat.
- i_data  in  BUS_W  payload beat; bit 0 is the first (highest-order) bit of the beat.
- i_last  in  1  final beat of a codeword.
- i_crc  in  CRC_W  received check bits; sampled only on the i_last beat.
- o_valid  out  1  decoded word available.
- o_ready  in  1  downstream accepts the word.
- o_data  out  DATA_W  assembled payload; first beat lands in bits [0:BUS_W-1].
- o_haserr  out  1  syndrome nonzero OR length error.
- o_lenerr  out  1  beat-count mismatch.
- o_synd  out  CRC_W  computed remainder XOR i_crc.
- o_errcnt  out  CNT_W  count of words delivered with o_haserr=1.

Behaviour:
- Reset (synchronous, active-high): state=COLLECT; beat count, LFSR, o_data, o_synd, o_errcnt all cleared; o_valid=0; o_haserr=0; o_lenerr=0; i_ready=1 on the first cycle after reset deasserts.
- Number of beats per word: NB = DATA_W/BUS_W.
- A beat transfers when i_valid && i_ready.
- Polynomial: the LFSR computes M(x)*x^CRC_W mod G, MSB-first, processing all BUS_W bits of an accepted beat in one cycle.
  - Next-state logic is generated from POLY; there are no hardcoded XOR trees.
- Syndrome: o_synd = final LFSR value XOR i_crc. A valid codeword gives o_synd=0.
- State COLLECT:
  - i_ready=1.
  - Each accepted beat is written into the payload shift register at slot beat_cnt, the LFSR is updated, and beat_cnt increments.
  - The word ends on the first of these two events:
    - i_last=1, or
    - beat_cnt==NB-1 (forced end).
  - Length error is set if either:
    - i_last=1 with beat_cnt!=NB-1 (early end: unfilled slots are output as zero; the syndrome is still computed over the beats received), or
    - beat_cnt==NB-1 with i_last=0 (missing last: i_crc is still sampled on that beat).
  - At word end, register o_data, o_synd, o_lenerr, and o_haserr=(|synd)|lenerr. Set o_valid=1 and go to HOLD.
  - Clear LFSR and beat_cnt for the next word.
- Latency: o_valid rises 1 cycle after the final beat is accepted.
- State HOLD:
  - i_ready=0.
  - o_valid and all o_* fields are held stable until o_ready=1.
  - On o_valid && o_ready: o_valid=0 next cycle and return to COLLECT.
  - No bypass: the minimum gap is one cycle between the last beat of word k and the first beat of word k+1 (throughput NB+1 cycles per word with o_ready tied high).
- Error counter: increments by 1 on each output handshake with o_haserr=1. Saturates at all-ones, with no wrap.
- i_valid=0 mid-word: hold state; no timeout.
- Reset mid-word or in HOLD: the partial word is discarded and no o_valid is produced.
- i_data, i_last and i_crc are ignored when i_valid=0 or i_ready=0.

Test Plan:
- Zero payload, i_crc=0, 4 beats, last on beat 3, o_ready=1 → o_valid one cycle later; o_synd=0, o_haserr=0, o_data=0, o_errcnt=0.
- Payload with only the final bit set (beat 3 = 32'h00000001), i_crc=6'b000011 (x^6 mod G = x+1) → o_synd=0, o_haserr=0. Same beats with i_crc=0 → o_synd=6'b000011, o_haserr=1, o_errcnt=1.
- Random payload with correct CRC from the reference model, then each single data-bit flip in turn → every flip gives o_haserr=1 and nonzero o_synd; o_data equals the flipped payload.
- i_last on beat 1 → o_lenerr=1, o_haserr=1, o_data beats 2..3 zero. Then 4 beats without i_last → word ends at beat 3 with o_lenerr=1.
- Hold o_ready=0 for 5 cycles after o_valid → i_ready=0, outputs stable, no beat accepted. Release → one handshake, i_ready=1 next cycle.
- Assert reset mid-word (after 2 beats), then send a clean word → no spurious o_valid; clean word gives o_haserr=0. Saturation check: with CNT_W=2, send 5 bad words → o_errcnt=3.

Source files
------------

// File: rtl/crc_stream_dec_if.sv
// Purpose: bundles the beat input stream and the decoded-word output of crc_stream_dec.
// Latency: none; signals only.
// Backpressure: i_ready from the decoder throttles beats; o_ready from the consumer holds the word.
interface crc_stream_dec_if #(
  parameter int DATA_W = 128,
  parameter int BUS_W  = 32,
  parameter int CRC_W  = 6,
  parameter int CNT_W  = 16
) ();

  logic              i_valid;
  logic              i_ready;
  logic [BUS_W-1:0]  i_data;
  logic              i_last;
  logic [CRC_W-1:0]  i_crc;
  logic              o_valid;
  logic              o_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_haserr;
  logic              o_lenerr;
  logic [CRC_W-1:0]  o_synd;
  logic [CNT_W-1:0]  o_errcnt;

  // Decoder side: consumes beats, produces the word.
  modport slave (
    input  i_valid, i_data, i_last, i_crc, o_ready,
    output i_ready, o_valid, o_data, o_haserr, o_lenerr, o_synd, o_errcnt
  );

  // Environment side: produces beats, consumes the word.
  modport master (
    output i_valid, i_data, i_last, i_crc, o_ready,
    input  i_ready, o_valid, o_data, o_haserr, o_lenerr, o_synd, o_errcnt
  );

endinterface

// File: rtl/crc_stream_dec.sv
// Purpose: beat-serial CRC checker; assembles DATA_W payload from BUS_W beats, reports syndrome/length errors.
// Latency: o_valid rises 1 cycle after the final beat is accepted; NB+1 cycles per word at full rate.
// Backpressure: i_ready drops while a decoded word waits in HOLD; word fields stay stable until o_ready.
module crc_stream_dec #(
  parameter int                DATA_W = 128,
  parameter int                BUS_W  = 32,
  parameter int                CRC_W  = 6,
  parameter logic [CRC_W-1:0]  POLY   = 6'h03,
  parameter int                CNT_W  = 16
) (
  input  logic            clk,
  input  logic            reset,
  crc_stream_dec_if.slave io
);

  localparam int NB = DATA_W / BUS_W;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(NB - 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CRC_W-1:0]  lfsr_q, lfsr_d;
  logic [DATA_W-1:0] pay_q, pay_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic [CRC_W-1:0]  synd_q, synd_d;
  logic              lenerr_q, lenerr_d;
  logic              haserr_q, haserr_d;
  logic              vld_q, vld_d;
  logic [CNT_W-1:0]  errcnt_q, errcnt_d;

  logic [CRC_W-1:0]  lfsr_nxt;
  logic [DATA_W-1:0] pay_ins;
  logic [CRC_W-1:0]  synd_now;
  logic              at_last;
  logic              lenerr_now;

  // LFSR advanced over every bit of the beat, bit 0 first; taps come from POLY.
  always_comb begin
    lfsr_nxt = lfsr_q;
    for (int i = 0; i < BUS_W; i++) begin
      lfsr_nxt = (lfsr_nxt << 1) ^ ({CRC_W{lfsr_nxt[CRC_W-1] ^ io.i_data[i]}} & POLY);
    end
  end

  // Payload with the current beat dropped into its slot; untouched slots stay zero.
  always_comb begin
    pay_ins = pay_q;
    pay_ins[cnt_q*BUS_W +: BUS_W] = io.i_data;
  end

  assign at_last    = (cnt_q == LAST_SLOT);
  assign lenerr_now = io.i_last ^ at_last;   // early i_last, or forced end without i_last
  assign synd_now   = lfsr_nxt ^ io.i_crc;

  // Next-state: collect beats, close the word on i_last or a full slot count, then hold for o_ready.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    pay_d    = pay_q;
    odata_d  = odata_q;
    synd_d   = synd_q;
    lenerr_d = lenerr_q;
    haserr_d = haserr_q;
    vld_d    = vld_q;
    errcnt_d = errcnt_q;
    case (state_q)
      COLLECT: begin
        if (io.i_valid) begin
          if (io.i_last || at_last) begin
            odata_d  = pay_ins;
            synd_d   = synd_now;
            lenerr_d = lenerr_now;
            haserr_d = (|synd_now) | lenerr_now;
            vld_d    = 1'b1;
            state_d  = HOLD;
            cnt_d    = '0;
            lfsr_d   = '0;
            pay_d    = '0;
          end else begin
            pay_d  = pay_ins;
            lfsr_d = lfsr_nxt;
            cnt_d  = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (io.o_ready) begin
          vld_d   = 1'b0;
          state_d = COLLECT;
          if (haserr_q && (errcnt_q != {CNT_W{1'b1}})) begin
            errcnt_d = errcnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State registers with synchronous reset discarding any partial or held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= COLLECT;
      cnt_q    <= '0;
      lfsr_q   <= '0;
      pay_q    <= '0;
      odata_q  <= '0;
      synd_q   <= '0;
      lenerr_q <= 1'b0;
      haserr_q <= 1'b0;
      vld_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      pay_q    <= pay_d;
      odata_q  <= odata_d;
      synd_q   <= synd_d;
      lenerr_q <= lenerr_d;
      haserr_q <= haserr_d;
      vld_q    <= vld_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign io.i_ready  = (state_q == COLLECT);
  assign io.o_valid  = vld_q;
  assign io.o_data   = odata_q;
  assign io.o_synd   = synd_q;
  assign io.o_lenerr = lenerr_q;
  assign io.o_haserr = haserr_q;
  assign io.o_errcnt = errcnt_q;

endmodule
